// File: rtl/ecg_preproc_sequencer_if.sv
// Handshake bundle between the ECG preprocessing sequencer and its ADC,
// filter datapath and downstream consumer. master = sequencer side.
interface ecg_preproc_sequencer_if #(
  parameter int DATA_W = 32
) ();
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              pp_start;
  logic [DATA_W-1:0] pp_din;
  logic              pp_done;
  logic [DATA_W-1:0] pp_dout;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    input  adc_valid, adc_data, pp_done, pp_dout, out_ready,
    output pp_start, pp_din, out_valid, out_data
  );

  modport slave (
    output adc_valid, adc_data, pp_done, pp_dout, out_ready,
    input  pp_start, pp_din, out_valid, out_data
  );
endinterface

// File: rtl/ecg_preproc_sequencer.sv
// ECG preprocessing sequencer: sample-rate tick, input FIFO, start/done issue FSM.
// Optional datapath watchdog enabled by defining PREPROC_TIMEOUT_EN.
module ecg_preproc_sequencer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 250,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  output logic                          sample_tick,
  ecg_preproc_sequencer_if.master       link,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t            state;
  logic [CW-1:0]     tick_cnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;

  assign empty = (fifo_level == '0);
  assign full  = (fifo_level == LW'(FIFO_DEPTH));
  assign pop   = (state == IDLE) && enable && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push  = link.adc_valid && (!full || pop);

  // Tick is registered one count early so it is high while the count reads DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else if (enable) begin
      tick_cnt    <= (tick_cnt == CW'(DIV - 1)) ? '0 : tick_cnt + CW'(1);
      sample_tick <= (tick_cnt == CW'(DIV - 2));
    end else begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= link.adc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LW'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LW'(1);
      end
      if (link.adc_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PREPROC_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
`else
  // Watchdog absent: the error flag is a constant tie-off.
  assign timeout_err = 1'b0 & (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      link.pp_start  <= 1'b0;
      link.pp_din    <= '0;
      link.out_valid <= 1'b0;
      link.out_data  <= '0;
      busy           <= 1'b0;
`ifdef PREPROC_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            link.pp_din   <= mem[rd_ptr];
            link.pp_start <= 1'b1;
            busy          <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          link.pp_start <= 1'b0;
          state         <= WAIT;
`ifdef PREPROC_TIMEOUT_EN
          wait_cnt      <= '0;
`endif
        end
        WAIT: begin
          if (link.pp_done) begin
            link.out_data  <= link.pp_dout;
            link.out_valid <= 1'b1;
            state          <= OUT;
          end
`ifdef PREPROC_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
`endif
        end
        OUT: begin
          if (link.out_ready) begin
            link.out_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_preproc_sequencer.sv
// Bench for ecg_preproc_sequencer: queue-based reference model compared every
// cycle, directed scenarios with literal timing expectations, then random traffic.
module tb_ecg_preproc_sequencer;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = 250;
  localparam int TIMEOUT    = 64;

  localparam int S_IDLE  = 0;
  localparam int S_START = 1;
  localparam int S_WAIT  = 2;
  localparam int S_OUT   = 3;

  logic clk = 1'b0;
  logic rst_n, enable, sample_tick, overflow, busy, timeout_err;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  ecg_preproc_sequencer_if #(.DATA_W(DATA_W)) link ();

  ecg_preproc_sequencer #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV(DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_tick(sample_tick),
    .link(link), .fifo_level(fifo_level), .overflow(overflow),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: a sample queue plus the life of the one in-flight sample.
  int          m_cnt;
  bit          m_tick, m_start, m_oval, m_ovf;
  logic [31:0] m_q[$];
  int          m_stage;
  logic [31:0] m_din, m_odata;

  always @(posedge clk) begin
    bit          take;
    logic [31:0] head;
    cyc++;
    if (!rst_n) begin
      m_cnt = 0; m_tick = 0; m_start = 0; m_oval = 0; m_ovf = 0;
      m_q.delete(); m_stage = S_IDLE; m_din = '0; m_odata = '0;
    end else begin
      m_cnt  = enable ? (m_cnt + 1) % DIV : 0;
      m_tick = enable && (m_cnt == DIV - 1);
      take   = (m_stage == S_IDLE) && enable && (m_q.size() > 0);
      head   = '0;
      if (take) head = m_q.pop_front();
      if (link.adc_valid) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(link.adc_data);
        else m_ovf = 1;
      end
      m_start = 0;
      case (m_stage)
        S_IDLE:  if (take) begin m_din = head; m_start = 1; m_stage = S_START; end
        S_START: m_stage = S_WAIT;
        S_WAIT:  if (link.pp_done) begin m_odata = link.pp_dout; m_oval = 1; m_stage = S_OUT; end
        S_OUT:   if (link.out_ready) begin m_oval = 0; m_stage = S_IDLE; end
        default: m_stage = S_IDLE;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("sample_tick", sample_tick, m_tick);
    chk("pp_start", link.pp_start, m_start);
    chk("pp_din", link.pp_din, m_din);
    chk("out_valid", link.out_valid, m_oval);
    chk("out_data", link.out_data, m_odata);
    chk("fifo_level", fifo_level, m_q.size());
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_stage != S_IDLE);
    chk("timeout_err", timeout_err, 1'b0);
  endtask

  // Datapath emulation and event stamps
  bit          dp_rand = 0;
  bit          dp_armed = 0;
  int          dp_delay = 2;
  int          dp_cnt = 0;
  logic [31:0] dp_res = '0;
  int          st_cyc, dn_cyc, ov_cyc, ov_n, n_start;
  logic [31:0] st_din, ov_dat;
  int          tick_q[$];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    if (link.pp_start) begin st_cyc = cyc; st_din = link.pp_din; n_start++; end
    if (link.out_valid) begin
      if (ov_n == 0) begin ov_cyc = cyc; ov_dat = link.out_data; end
      ov_n++;
    end
    if (sample_tick) tick_q.push_back(cyc);
    #1;
    link.pp_done = 1'b0;
    link.pp_dout = $urandom;
    if (link.pp_start) begin
      dp_armed = 1;
      dp_cnt   = dp_rand ? $urandom_range(1, 6) : dp_delay;
    end else if (dp_armed) begin
      dp_cnt--;
      if (dp_cnt == 0) begin
        link.pp_done = 1'b1;
        link.pp_dout = dp_rand ? $urandom : dp_res;
        dp_armed = 0;
        dn_cyc = cyc;
      end
    end
  endtask

  task automatic push1(input logic [31:0] d);
    link.adc_valid = 1'b1;
    link.adc_data  = d;
    step();
    link.adc_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (link.pp_start) seen = 1;
    end
    chk("wait_start_bound", seen, 1'b1);
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    link.out_ready = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (fifo_level == 0 && !busy) done = 1;
    end
    chk("drain_bound", done, 1'b1);
  endtask

  int t, u;
  int exp_t[3] = '{259, 509, 759};

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    link.adc_valid = 1'b0; link.adc_data = '0; link.out_ready = 1'b0;
    link.pp_done = 1'b0; link.pp_dout = '0;
    st_cyc = -1; dn_cyc = -1; ov_cyc = -1; ov_n = 0; n_start = 0;
    st_din = '0; ov_dat = '0;

    // Reset state
    repeat (3) step();
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", link.out_valid, 0);
    chk("rst_pp_start", link.pp_start, 0);
    rst_n = 1'b1;

    // Tick period: enable rises at cycle 10
    while (cyc < 10) step();
    tick_q.delete();
    enable = 1'b1;
    while (cyc < 760) step();
    enable = 1'b0;
    repeat (300) step();
    chk("tick_count", tick_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("tick_cycle", (i < tick_q.size()) ? tick_q[i] : -1, exp_t[i]);

    // Full FIFO with simultaneous pop and push
    push1(32'h11); push1(32'h22); push1(32'h33); push1(32'h44);
    chk("full_level", fifo_level, 4);
    enable = 1'b1;
    push1(32'h55);
    chk("pushpop_level", fifo_level, 4);
    chk("pushpop_overflow", overflow, 0);
    dp_delay = 2;
    drain(200);

    // Single sample latency
    ov_n = 0; st_cyc = -1; dn_cyc = -1;
    dp_delay = 5; dp_res = 32'h456; link.out_ready = 1'b1;
    t = cyc;
    push1(32'h123);
    repeat (12) step();
    chk("lat_start_cyc", st_cyc, t + 2);
    chk("lat_pp_din", st_din, 32'h123);
    chk("lat_done_cyc", dn_cyc, t + 7);
    chk("lat_out_cyc", ov_cyc, t + 8);
    chk("lat_out_data", ov_dat, 32'h456);
    chk("lat_out_cycles", ov_n, 1);

    // Back-pressure with three samples queued behind the held result
    link.out_ready = 1'b0; dp_delay = 3; dp_res = 32'hCAFE0001; ov_n = 0;
    push1(32'hA1);
    for (int i = 0; i < 30 && ov_n == 0; i++) step();
    chk("bp_out_valid_bound", ov_n > 0, 1'b1);
    n_start = 0;
    push1(32'hB1); push1(32'hB2); push1(32'hB3);
    repeat (17) step();
    chk("bp_no_start", n_start, 0);
    chk("bp_level", fifo_level, 3);
    chk("bp_out_data", link.out_data, 32'hCAFE0001);
    chk("bp_out_valid", link.out_valid, 1'b1);
    u = cyc;
    link.out_ready = 1'b1;
    step(); step();
    chk("bp_restart_start", link.pp_start, 1'b1);
    chk("bp_restart_din", link.pp_din, 32'hB1);
    chk("bp_restart_cyc", st_cyc, u + 2);
    drain(300);

    // Overflow while the datapath is slow
    dp_delay = 20;
    push1(32'hD0);
    wait_start(10);
    for (int i = 0; i < 5; i++) begin
      link.adc_valid = 1'b1;
      link.adc_data  = 32'hE0 + i;
      step();
    end
    link.adc_valid = 1'b0;
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1'b1);
    drain(400);
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_drained", fifo_level, 0);

    // Reset while waiting on the datapath
    dp_delay = 10;
    push1(32'hF0);
    wait_start(10);
    step(); step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pp_start", link.pp_start, 0);
    chk("mid_rst_pp_din", link.pp_din, 0);
    chk("mid_rst_out_valid", link.out_valid, 0);
    chk("mid_rst_out_data", link.out_data, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_tick", sample_tick, 0);
    rst_n = 1'b1;
    ov_n = 0;
    repeat (20) step();
    chk("mid_rst_no_out", ov_n, 0);

    // Random traffic
    dp_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      rst_n          = ($urandom_range(0, 599) != 0);
      enable         = ($urandom_range(0, 15) != 0);
      link.adc_valid = ($urandom_range(0, 99) < 30);
      link.adc_data  = $urandom;
      link.out_ready = ($urandom_range(0, 99) < 60);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
